// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async FIFO constants and Gray code helpers
package fifo_pkg;

    localparam int PTR_WIDTH_DEF = 3;
    localparam int DEPTH_DEF     = 2 ** PTR_WIDTH_DEF;

    // Width-agnostic: callers zero-extend into 32 bits and truncate the result
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - parameterized-width two-flop clock domain synchronizer
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops give the first stage a full cycle to resolve
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_wptr_ctrl.sv
// rtl/fifo_wptr_ctrl.sv - async FIFO write-domain pointer and status controller
module fifo_wptr_ctrl
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH    = PTR_WIDTH_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int AFULL_THRESH = 6
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 w_en,
    input  logic                 ovf_clr,
    input  logic [PTR_WIDTH:0]   g_rptr,
    output logic [PTR_WIDTH:0]   b_wptr,
    output logic [PTR_WIDTH:0]   g_wptr,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   wr_level,
    output logic                 wr_ack,
    output logic                 overflow
);

    localparam int PW = PTR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_L = PW'(AFULL_THRESH);
    // Gray code of DEPTH flips the two MSBs: a write pointer exactly DEPTH
    // ahead of the read pointer differs from it in just those bits
    localparam logic [PW-1:0] FULL_MASK = PW'(bin2gray(32'(DEPTH)));

    logic [PW-1:0] g_rptr_s;
    logic [PW-1:0] rptr_bin;
    logic [PW-1:0] b_wptr_nxt;
    logic [PW-1:0] g_wptr_nxt;
    logic [PW-1:0] level_nxt;
    logic          accept;

    sync_2ff #(
        .WIDTH (PW)
    ) u_rptr_sync (
        .clk (wclk),
        .rst (wrst),
        .d   (g_rptr),
        .q   (g_rptr_s)
    );

    // Next-pointer and occupancy arithmetic; accept matches the storage write enable
    always_comb begin
        accept     = w_en & ~full;
        b_wptr_nxt = b_wptr + PW'(accept);
        g_wptr_nxt = PW'(bin2gray(32'(b_wptr_nxt)));
        rptr_bin   = PW'(gray2bin(32'(g_rptr_s)));
        level_nxt  = b_wptr_nxt - rptr_bin;
    end

    // Binary and Gray write pointers advance on the accepting edge
    always_ff @(posedge wclk) begin
        if (wrst) begin
            b_wptr <= '0;
            g_wptr <= '0;
        end else begin
            b_wptr <= b_wptr_nxt;
            g_wptr <= g_wptr_nxt;
        end
    end

    // Registered status from the synchronized (possibly stale) read pointer
    always_ff @(posedge wclk) begin
        if (wrst) begin
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            wr_ack      <= 1'b0;
        end else begin
            full        <= (g_wptr_nxt == (g_rptr_s ^ FULL_MASK));
            almost_full <= (level_nxt >= AFULL_L);
            wr_level    <= level_nxt;
            wr_ack      <= accept;
        end
    end

    // Sticky overflow; a rejected write in the clearing cycle keeps it set
    always_ff @(posedge wclk) begin
        if (wrst) begin
            overflow <= 1'b0;
        end else if (w_en && full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// tb/tb_fifo_wptr_ctrl.sv - scoreboard bench for fifo_wptr_ctrl
module tb_fifo_wptr_ctrl;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic       w_en = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [3:0] g_rptr = 4'd0;
    logic [3:0] b_wptr;
    logic [3:0] g_wptr;
    logic       full;
    logic       almost_full;
    logic [3:0] wr_level;
    logic       wr_ack;
    logic       overflow;

    fifo_wptr_ctrl #(
        .PTR_WIDTH    (3),
        .DEPTH        (8),
        .AFULL_THRESH (6)
    ) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .w_en        (w_en),
        .ovf_clr     (ovf_clr),
        .g_rptr      (g_rptr),
        .b_wptr      (b_wptr),
        .g_wptr      (g_wptr),
        .full        (full),
        .almost_full (almost_full),
        .wr_level    (wr_level),
        .wr_ack      (wr_ack),
        .overflow    (overflow)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        int b;
        int g;
        int lvl;
        int full;
        int af;
        int ack;
        int ovf;
        int rst;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   wrapped = 0;

    // Reference model state: total writes ever accepted, reader pointer history
    int m_wtot = 0;
    int m_full = 0;
    int m_ovf = 0;
    int m_seen_d1 = 0;
    int m_seen_d2 = 0;
    int rd_tot = 0;

    function automatic void chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
        end
    endfunction

    function automatic int gray_of(input int x);
        return x ^ (x >> 1);
    endfunction

    function automatic int gray_decode(input int g);
        for (int i = 0; i < 16; i++) begin
            if (gray_of(i) == g) return i;
        end
        return 0;
    endfunction

    // Drive one cycle of inputs and push the state expected after the next edge
    task automatic step(input bit we, input bit clr, input int rd_bin, input bit rst);
        exp_t e;
        int   acc;
        int   seen;
        int   occ;
        @(negedge wclk);
        w_en    = we;
        ovf_clr = clr;
        g_rptr  = 4'(gray_of(rd_bin % 16));
        wrst    = rst;
        if (rst) begin
            m_wtot = 0; m_full = 0; m_ovf = 0;
            m_seen_d1 = 0; m_seen_d2 = 0;
            e = '{b:0, g:0, lvl:0, full:0, af:0, ack:0, ovf:0, rst:1};
        end else begin
            acc = (we && m_full == 0) ? 1 : 0;
            if (we && m_full != 0) m_ovf = 1;
            else if (clr) m_ovf = 0;
            m_wtot += acc;
            seen = m_seen_d2;
            m_seen_d2 = m_seen_d1;
            m_seen_d1 = gray_decode(gray_of(rd_bin % 16));
            occ = ((m_wtot % 16) - seen + 16) % 16;
            m_full = (occ == 8) ? 1 : 0;
            e.b = m_wtot % 16;
            e.g = gray_of(m_wtot % 16);
            e.lvl = occ;
            e.full = m_full;
            e.af = (occ >= 6) ? 1 : 0;
            e.ack = acc;
            e.ovf = m_ovf;
            e.rst = 0;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: after each edge, pop the expected state and compare every output
    initial begin
        exp_t e;
        int   prev_b;
        int   prev_g;
        prev_b = 0;
        prev_g = 0;
        forever begin
            @(posedge wclk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("b_wptr", int'(b_wptr), e.b);
                chk("g_wptr", int'(g_wptr), e.g);
                chk("wr_level", int'(wr_level), e.lvl);
                chk("full", int'(full), e.full);
                chk("almost_full", int'(almost_full), e.af);
                chk("wr_ack", int'(wr_ack), e.ack);
                chk("overflow", int'(overflow), e.ovf);
                if (e.rst == 0 && e.ack != 0) begin
                    chk("g_wptr_hamming", $countones(4'(prev_g) ^ g_wptr), 1);
                    if (prev_b == 15 && b_wptr == 4'd0) wrapped = 1;
                end
                prev_b = int'(b_wptr);
                prev_g = int'(g_wptr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int budget;
        bit we;

        // Reset, including a write request that reset must override
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);

        // Fill to full with the reader parked at zero
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);

        // Writes while full are rejected and set overflow, then clear it
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // Reader jumps to 3; status follows three edges later
        for (int i = 0; i < 5; i++) step(0, 0, 3, 0);

        // Refill to full, then reject a write while clearing overflow
        for (int i = 0; i < 3; i++) step(1, 0, 3, 0);
        step(1, 1, 3, 0);
        step(0, 0, 3, 0);

        // Fresh start; 20 writes with a reader trailing two entries behind
        step(0, 0, 0, 1);
        rd_tot = 0;
        accepted = 0;
        budget = 0;
        wrapped = 0;
        while (accepted < 20 && budget < 200) begin
            rd_tot = (m_wtot >= 2) ? m_wtot - 2 : 0;
            we = ($urandom_range(0, 3) != 0);
            step(we, 0, rd_tot, 0);
            if (we) accepted++;
            budget++;
        end
        step(0, 0, rd_tot, 0);
        step(0, 0, rd_tot, 0);
        chk("write_budget", (accepted >= 20) ? 1 : 0, 1);
        chk("b_wptr_wrapped", int'(wrapped), 1);

        // Reset at b_wptr=5 together with a write request
        step(0, 0, 0, 1);
        rd_tot = 0;
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        step(0, 0, 0, 0);

        // Randomized traffic: reader advances at random but never passes the writer
        rd_tot = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0 && m_wtot > rd_tot) begin
                rd_tot += $urandom_range(0, m_wtot - rd_tot);
            end
            step($urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, rd_tot, 0);
        end

        @(negedge wclk);
        w_en = 1'b0;
        ovf_clr = 1'b0;
        @(negedge wclk);
        @(negedge wclk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
